vec_load_store_unit: RTL and testbench

Upstream/downstream neighbour of the 4x512-bit vector register file. Moves one 512-bit vector between a 32-bit word-addressed memory port and a register-file entry.
- Load: fetch 16 words from memory, assemble them, then issue a single register-file write (op 00).
- Store: issue a register-file read (op 01), capture the vector, then write 16 words to memory.
- A top-level mux gives this block the register-file op/addr/data lines while rf_op_valid=1.

---
 rtl/vec_pkg.sv | 29 ++
 rtl/vec_word_buffer.sv | 51 +++++
 rtl/vec_load_store_unit.sv | 183 ++++++++++++++++++
 tb/tb_vec_load_store_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the vector load/store path.
//   DATA_W / WORD_W / LANES : vector width, memory word width, words per vector
//   RF_OP_*                 : register-file operation codes driven on rf_op_code
//   lsu_state_t             : load/store sequencer states (also used by the arbiter)
package vec_pkg;

  localparam int DATA_W = 512;
  localparam int WORD_W = 32;
  localparam int LANES  = DATA_W / WORD_W;
  localparam int LANE_W = $clog2(LANES);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  localparam logic [1:0] RF_OP_WRITE = 2'b00;
  localparam logic [1:0] RF_OP_READ  = 2'b01;
  localparam logic [1:0] RF_OP_ALU   = 2'b10;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LD_REQ     = 3'd1,
    LD_WAIT    = 3'd2,
    LD_COMMIT  = 3'd3,
    ST_READ    = 3'd4,
    ST_CAPTURE = 3'd5,
    ST_REQ     = 3'd6,
    DONE       = 3'd7
  } lsu_state_t;

endpackage

// File: rtl/vec_word_buffer.sv
// Staging buffer holding one vector as LANES words.
//   clk, rst   : clock, asynchronous active-low reset (clears all words)
//   wr_en      : write wr_word into lane wr_lane
//   load_en    : overwrite every lane from load_vec (has priority over wr_en)
//   rd_lane    : lane selected onto rd_word
//   vec        : whole buffer as a flat vector, lane 0 in the low bits
module vec_word_buffer
  import vec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [LANE_W-1:0] wr_lane,
  input  logic [WORD_W-1:0] wr_word,
  input  logic              load_en,
  input  logic [DATA_W-1:0] load_vec,
  input  logic [LANE_W-1:0] rd_lane,
  output logic [WORD_W-1:0] rd_word,
  output logic [DATA_W-1:0] vec
);

  // Flops rather than RAM: the full vector is needed in parallel on both
  // the load side and the read-out side.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [WORD_W-1:0] word_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          word_reg <= '0;
        end else if (load_en) begin
          word_reg <= load_vec[gi*WORD_W +: WORD_W];
        end else if (wr_en && (wr_lane == LANE_W'(gi))) begin
          word_reg <= wr_word;
        end
      end

      assign vec[gi*WORD_W +: WORD_W] = word_reg;
    end
  endgenerate

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < LANES; i++) begin
      if (rd_lane == LANE_W'(i)) begin
        rd_word = vec[i*WORD_W +: WORD_W];
      end
    end
  end

endmodule

// File: rtl/vec_load_store_unit.sv
// Moves one vector between a word-addressed memory port and a register-file entry.
//   clk, rst          : clock, asynchronous active-low reset (aborts any command)
//   cmd_*             : command handshake; cmd_ready only in IDLE
//   done              : one-cycle completion pulse
//   mem_*             : single-outstanding word memory port (req held until gnt)
//   rf_op_valid/code  : register-file op ownership and code (write 00 / read 01)
//   rf_read_addr/data : register read; data valid the cycle after the read op
//   rf_write_addr/data: register write of the assembled vector
module vec_load_store_unit
  import vec_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_is_store,
  input  logic [1:0]        cmd_reg,
  input  logic [ADDR_W-1:0] cmd_base,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              rf_op_valid,
  output logic [1:0]        rf_op_code,
  output logic [1:0]        rf_read_addr,
  output logic [1:0]        rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [DATA_W-1:0] rf_read_data
);

  lsu_state_t        state_reg, state_next;
  logic [LANE_W-1:0] lane_reg, lane_next;
  logic              is_store_reg, is_store_next;
  logic [1:0]        reg_idx_reg, reg_idx_next;
  logic [ADDR_W-1:0] base_reg, base_next;

  logic              buf_wr_en;
  logic              buf_load_en;
  logic [WORD_W-1:0] buf_rd_word;
  logic [DATA_W-1:0] buf_vec;
  logic [ADDR_W-1:0] cur_addr;

  // Natural width truncation gives the modulo-2^ADDR_W wrap.
  assign cur_addr = base_reg + ADDR_W'(lane_reg);

  vec_word_buffer u_buffer (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (buf_wr_en),
    .wr_lane  (lane_reg),
    .wr_word  (mem_rdata),
    .load_en  (buf_load_en),
    .load_vec (rf_read_data),
    .rd_lane  (lane_reg),
    .rd_word  (buf_rd_word),
    .vec      (buf_vec)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      lane_reg     <= '0;
      is_store_reg <= 1'b0;
      reg_idx_reg  <= '0;
      base_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      lane_reg     <= lane_next;
      is_store_reg <= is_store_next;
      reg_idx_reg  <= reg_idx_next;
      base_reg     <= base_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    lane_next     = lane_reg;
    is_store_next = is_store_reg;
    reg_idx_next  = reg_idx_reg;
    base_next     = base_reg;

    cmd_ready     = 1'b0;
    done          = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    rf_op_valid   = 1'b0;
    rf_op_code    = RF_OP_WRITE;
    rf_read_addr  = '0;
    rf_write_addr = '0;
    rf_write_data = '0;
    buf_wr_en     = 1'b0;
    buf_load_en   = 1'b0;

    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          is_store_next = cmd_is_store;
          reg_idx_next  = cmd_reg;
          base_next     = cmd_base;
          lane_next     = '0;
          state_next    = cmd_is_store ? ST_READ : LD_REQ;
        end
      end

      LD_REQ: begin
        mem_req  = 1'b1;
        mem_we   = is_store_reg;  // latched direction, always 0 on the load path
        mem_addr = cur_addr;
        if (mem_gnt) begin
          state_next = LD_WAIT;
        end
      end

      LD_WAIT: begin
        // Only this state listens to rvalid, so stray beats elsewhere are dropped.
        if (mem_rvalid) begin
          buf_wr_en = 1'b1;
          if (lane_reg == LAST_LANE) begin
            state_next = LD_COMMIT;
          end else begin
            lane_next  = lane_reg + 1'b1;
            state_next = LD_REQ;
          end
        end
      end

      LD_COMMIT: begin
        rf_op_valid   = 1'b1;
        rf_op_code    = RF_OP_WRITE;
        rf_write_addr = reg_idx_reg;
        rf_write_data = buf_vec;
        state_next    = DONE;
      end

      ST_READ: begin
        rf_op_valid  = 1'b1;
        rf_op_code   = RF_OP_READ;
        rf_read_addr = reg_idx_reg;
        state_next   = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        // Register file returns read data one cycle after the op.
        buf_load_en = 1'b1;
        lane_next   = '0;
        state_next  = ST_REQ;
      end

      ST_REQ: begin
        mem_req   = 1'b1;
        mem_we    = is_store_reg;
        mem_addr  = cur_addr;
        mem_wdata = buf_rd_word;
        if (mem_gnt) begin
          if (lane_reg == LAST_LANE) begin
            state_next = DONE;
          end else begin
            lane_next = lane_reg + 1'b1;
          end
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vec_load_store_unit.sv
module tb_vec_load_store_unit;
  import vec_pkg::*;

  localparam int AW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_is_store = 1'b0;
  logic [1:0]        cmd_reg = '0;
  logic [AW-1:0]     cmd_base = '0;
  logic              done;
  logic              mem_req;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_gnt = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [WORD_W-1:0] mem_rdata = '0;
  logic              rf_op_valid;
  logic [1:0]        rf_op_code;
  logic [1:0]        rf_read_addr;
  logic [1:0]        rf_write_addr;
  logic [DATA_W-1:0] rf_write_data;
  logic [DATA_W-1:0] rf_read_data = '0;

  vec_load_store_unit #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_store(cmd_is_store),
    .cmd_reg(cmd_reg), .cmd_base(cmd_base), .done(done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_op_valid(rf_op_valid), .rf_op_code(rf_op_code), .rf_read_addr(rf_read_addr),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data), .rf_read_data(rf_read_data)
  );

  initial forever #5 clk = ~clk;

  typedef enum int {K_MEM, K_RF, K_DONE} kind_t;
  typedef struct {
    kind_t             kind;
    logic [AW-1:0]     addr;
    logic              we;
    logic [1:0]        code;
    logic [DATA_W-1:0] data;
    int                lat;
    int                acc;
  } exp_t;

  exp_t              exp_q[$];
  logic [WORD_W-1:0] mem [0:65535];
  logic [DATA_W-1:0] rf [0:3];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int max_gnt_stall = 0;
  int max_rv_stall = 0;
  bit spurious = 1'b0;
  int rv_count = 0;
  int last_done_cyc = -100;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [DATA_W-1:0] rand_vec();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*WORD_W +: WORD_W] = $urandom;
    return v;
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Pops the next expected event; counts as one comparison of event order.
  task automatic pop_expect(input kind_t k, input string name, output bit ok, output exp_t e);
    n_vec++;
    ok = 1'b0;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: DUT event with nothing expected (cycle %0d)", name, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k) begin
        n_bad++;
        $display("FAIL %s: got event kind %0d expected kind %0d (cycle %0d)", name, k, e.kind, cyc);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  // Memory model: random grant delay, random read latency, optional stray rvalid.
  initial begin : mem_responder
    int            stall_left;
    bit            rd_pend;
    int            rv_wait;
    logic [AW-1:0] rd_addr;
    stall_left = -1; rd_pend = 1'b0; rv_wait = 0; rd_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; rd_pend = 1'b0; stall_left = -1;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (rd_pend) begin
          if (rv_wait == 0) begin
            mem_rvalid = 1'b1; mem_rdata = mem[rd_addr]; rd_pend = 1'b0; rv_count++;
          end else begin
            rv_wait--;
          end
        end else if (spurious && $urandom_range(0, 3) == 0) begin
          mem_rvalid = 1'b1;
        end
        mem_gnt = 1'b0;
        if (mem_req) begin
          if (stall_left < 0) stall_left = $urandom_range(0, max_gnt_stall);
          if (stall_left == 0) begin
            mem_gnt = 1'b1; stall_left = -1;
            if (mem_we) mem[mem_addr] = mem_wdata;
            else begin
              rd_pend = 1'b1; rd_addr = mem_addr; rv_wait = $urandom_range(0, max_rv_stall);
            end
          end else begin
            stall_left--;
          end
        end
      end
    end
  end

  // Register-file model: read data valid only in the cycle after the read op.
  initial begin : rf_responder
    bit         rd_stage;
    logic [1:0] rd_reg;
    rd_stage = 1'b0; rd_reg = '0;
    forever begin
      @(negedge clk);
      if (rd_stage) begin rf_read_data = rf[rd_reg]; rd_stage = 1'b0; end
      else rf_read_data = rand_vec();
      if (!rst) rd_stage = 1'b0;
      else if (rf_op_valid) begin
        if (rf_op_code == RF_OP_READ) begin rd_stage = 1'b1; rd_reg = rf_read_addr; end
        else if (rf_op_code == RF_OP_WRITE) rf[rf_write_addr] = rf_write_data;
      end
    end
  end

  // Monitor: compares every DUT-presented event against the scoreboard queue.
  initial begin : monitor
    exp_t              e;
    bit                ok;
    bit                stalled;
    logic [AW-1:0]     s_addr;
    logic              s_we;
    logic [WORD_W-1:0] s_wdata;
    stalled = 1'b0; s_addr = '0; s_we = 1'b0; s_wdata = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        stalled = 1'b0;
      end else begin
        if (mem_req && !mem_gnt) begin
          if (stalled) begin
            check("stall_addr", mem_addr, s_addr);
            check("stall_we", mem_we, s_we);
            if (s_we) check("stall_wdata", mem_wdata, s_wdata);
          end
          stalled = 1'b1; s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata;
        end else begin
          stalled = 1'b0;
        end
        if (mem_req && mem_gnt) begin
          pop_expect(K_MEM, "mem_order", ok, e);
          if (ok) begin
            check("mem_addr", mem_addr, e.addr);
            check("mem_we", mem_we, e.we);
            if (e.we) check("mem_wdata", mem_wdata, e.data);
          end
        end
        if (rf_op_valid) begin
          pop_expect(K_RF, "rf_order", ok, e);
          if (ok) begin
            check("rf_op_code", rf_op_code, e.code);
            if (e.code == RF_OP_READ) check("rf_read_addr", rf_read_addr, e.addr);
            else begin
              check("rf_write_addr", rf_write_addr, e.addr);
              check("rf_write_data", rf_write_data, e.data);
            end
          end
        end
        if (done) begin
          pop_expect(K_DONE, "done_order", ok, e);
          if (ok) begin
            check("done_cmd_ready", cmd_ready, 1'b0);
            if (e.lat != 0) check("latency", cyc - e.acc + 1, e.lat);
          end
          last_done_cyc = cyc;
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_mem_req"}, mem_req, 1'b0);
    check({tag, "_mem_we"}, mem_we, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, '0);
    check({tag, "_mem_wdata"}, mem_wdata, '0);
    check({tag, "_rf_op_valid"}, rf_op_valid, 1'b0);
    check({tag, "_rf_op_code"}, rf_op_code, 2'b00);
    check({tag, "_rf_write_data"}, rf_write_data, '0);
  endtask

  // Issues one command; the reference result is computed from the memory and
  // register models at the moment the command is accepted.
  task automatic issue(input bit st, input logic [1:0] r, input logic [AW-1:0] b,
                       input bit keep, input bit chk_b2b);
    int                waitc;
    int                acc;
    exp_t              e;
    logic [DATA_W-1:0] v;
    logic [AW-1:0]     a;
    @(negedge clk);
    cmd_is_store = st; cmd_reg = r; cmd_base = b; cmd_valid = 1'b1;
    waitc = 0;
    while (!cmd_ready) begin
      if (waitc > 500) begin
        n_vec++; n_bad++;
        $display("FAIL cmd_accept: cmd_ready still 0 after %0d cycles, required 1", waitc);
        cmd_valid = 1'b0;
        return;
      end
      waitc++;
      @(negedge clk);
    end
    acc = cyc + 1;
    if (chk_b2b) check("b2b_accept_cycle", acc, last_done_cyc + 2);
    e.lat = 0; e.acc = acc; e.we = 1'b0; e.data = '0; e.code = RF_OP_WRITE; e.addr = '0;
    if (!st) begin
      v = '0;
      for (int i = 0; i < LANES; i++) begin
        a = b + AW'(i);
        v[i*WORD_W +: WORD_W] = mem[a];
        e.kind = K_MEM; e.addr = a; e.we = 1'b0; exp_q.push_back(e);
      end
      e.kind = K_RF; e.code = RF_OP_WRITE; e.addr = AW'(r); e.data = v; exp_q.push_back(e);
    end else begin
      v = rf[r];
      e.kind = K_RF; e.code = RF_OP_READ; e.addr = AW'(r); exp_q.push_back(e);
      for (int i = 0; i < LANES; i++) begin
        e.kind = K_MEM; e.addr = b + AW'(i); e.we = 1'b1;
        e.data = DATA_W'(v[i*WORD_W +: WORD_W]); exp_q.push_back(e);
      end
    end
    e.kind = K_DONE;
    e.lat  = (max_gnt_stall == 0 && max_rv_stall == 0) ? (st ? 19 : 2 * LANES + 2) : 0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (!keep) begin
      cmd_valid = 1'b0; cmd_reg = 2'($urandom); cmd_base = AW'($urandom); cmd_is_store = 1'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0) begin
      if (n > 5000) begin
        n_vec++; n_bad++;
        $display("FAIL completion: %0d expected events outstanding, required 0", exp_q.size());
        exp_q.delete();
        return;
      end
      n++;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [DATA_W-1:0] saved;
    int                rv_base;
    int                n;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) rf[i] = rand_vec();

    #1 rst = 1'b0;
    #2 check_idle_outputs("reset");
    repeat (3) @(negedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    // Directed load: words 0xA0000000+i at 0x0100.. into reg 2.
    for (int i = 0; i < LANES; i++) mem[16'h0100 + i] = 32'hA000_0000 + i;
    issue(1'b0, 2'd2, 16'h0100, 1'b0, 1'b0);
    wait_idle();
    check("ld_lane0", rf[2][31:0], 32'hA000_0000);
    check("ld_lane15", rf[2][511:480], 32'hA000_000F);

    // Directed store: reg 1 lane i = i*3 to 0x0040..
    for (int i = 0; i < LANES; i++) rf[1][i*WORD_W +: WORD_W] = i * 3;
    issue(1'b1, 2'd1, 16'h0040, 1'b0, 1'b0);
    wait_idle();
    for (int i = 0; i < LANES; i += 5) check("st_mem", mem[16'h0040 + i], i * 3);

    // Address wrap on a load.
    issue(1'b0, 2'd0, 16'hFFFE, 1'b0, 1'b0);
    wait_idle();

    // Random commands with grant/rvalid stalls and stray rvalid beats.
    max_gnt_stall = 5; max_rv_stall = 5; spurious = 1'b1;
    for (int t = 0; t < 12; t++) begin
      issue(1'($urandom), 2'($urandom), AW'($urandom), 1'b0, 1'b0);
      wait_idle();
    end
    max_gnt_stall = 0; max_rv_stall = 0; spurious = 1'b0;

    // Asynchronous reset in the middle of a load after 7 words.
    saved = rf[3];
    rv_base = rv_count;
    issue(1'b0, 2'd3, 16'h2000, 1'b0, 1'b0);
    n = 0;
    while (rv_count < rv_base + 7 && n < 500) begin n++; @(negedge clk); end
    check("abort_words_seen", (rv_count >= rv_base + 7), 1'b1);
    @(posedge clk);
    @(negedge clk);
    #3 rst = 1'b0;
    #1 check_idle_outputs("abort");
    exp_q.delete();
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_rf_write", rf[3], saved);
    issue(1'b0, 2'd3, 16'h2000, 1'b0, 1'b0);
    wait_idle();

    // cmd_valid held through DONE: second command waits for the next IDLE.
    issue(1'b0, 2'd1, AW'($urandom), 1'b1, 1'b0);
    issue(1'b1, 2'd1, AW'($urandom), 1'b0, 1'b1);
    wait_idle();

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
